// File: rtl/eth_phy_10g_pkg.sv
// Shared 10GBASE-R PCS definitions: sync headers, descrambler taps, BER monitor states.
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Polynomial x^58 + x^39 + 1
  localparam int unsigned DESCR_TAP_A = 39;
  localparam int unsigned DESCR_TAP_B = 58;

  localparam int unsigned ERR_W   = 6;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    BER_UNLOCKED = 2'd0,
    BER_MONITOR  = 2'd1,
    BER_HI_BER   = 2'd2
  } ber_state_t;

  function automatic logic sync_invalid(input logic [1:0] hdr);
    return !(hdr == SYNC_DATA || hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_ber_mon.sv
// Sync-header BER monitor: counts invalid headers per window of accepted blocks, flags hi_ber.
module eth_phy_10g_ber_mon
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned BER_WINDOW = 19531,
  parameter int unsigned BER_THRESH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             aligned,
  input  logic             valid,
  input  logic [1:0]       hdr,
  output logic             hi_ber,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned TW = $clog2(BER_WINDOW);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BER_WINDOW - 1);

  ber_state_t       state;
  logic [TW-1:0]    timer;
  logic [ERR_W-1:0] err_next;
  logic             over_thresh;

  always_comb begin
    err_next = err_count;
    if (sync_invalid(hdr) && err_count != ERR_MAX)
      err_next = err_count + 1'b1;
    over_thresh = 32'(err_next) >= BER_THRESH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BER_UNLOCKED;
      timer     <= '0;
      err_count <= '0;
      hi_ber    <= 1'b0;
    end else if (!aligned) begin
      state     <= BER_UNLOCKED;
      timer     <= '0;
      err_count <= '0;
      hi_ber    <= 1'b0;
    end else if (valid) begin
      // The last block's header still belongs to the closing window.
      if (timer == TIMER_LAST) begin
        timer     <= '0;
        err_count <= '0;
        if (over_thresh) begin
          state  <= BER_HI_BER;
          hi_ber <= 1'b1;
        end else begin
          state  <= BER_MONITOR;
          hi_ber <= 1'b0;
        end
      end else begin
        timer     <= timer + 1'b1;
        err_count <= err_next;
        if (state == BER_HI_BER || over_thresh) begin
          state  <= BER_HI_BER;
          hi_ber <= 1'b1;
        end else begin
          state  <= BER_MONITOR;
          hi_ber <= 1'b0;
        end
      end
    end else if (state == BER_UNLOCKED) begin
      state <= BER_MONITOR;
    end
  end

endmodule

// File: rtl/eth_phy_10g_rx_descrambler.sv
// 10GBASE-R receive descrambler (x^58 + x^39 + 1) with one-cycle registered latency and BER monitor.
module eth_phy_10g_rx_descrambler
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned BER_WINDOW = 19531,
  parameter int unsigned BER_THRESH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             aligned,
  input  logic             valid_in,
  input  logic [63:0]      data_in,
  input  logic [1:0]       hdr_in,
  output logic [63:0]      data_out,
  output logic [1:0]       hdr_out,
  output logic             valid_out,
  output logic             hi_ber,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned SW  = DESCR_TAP_B;
  localparam int unsigned LAG = DESCR_TAP_B - DESCR_TAP_A;

  logic [SW-1:0]    descr_state;
  logic [SW+63:0]   chain;
  logic [63:0]      descr;
  logic             accept;

  assign accept = valid_in & aligned;

  // chain[SW+i] is the current bit i; chain[LAG+i] and chain[i] are 39 and 58 bits earlier.
  always_comb begin
    chain = {data_in, descr_state};
    descr = '0;
    for (int unsigned i = 0; i < 64; i++)
      descr[i] = chain[SW+i] ^ chain[LAG+i] ^ chain[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      hdr_out     <= '0;
      valid_out   <= 1'b0;
      descr_state <= '0;
    end else begin
      valid_out <= accept;
      if (accept) begin
        data_out    <= descr;
        hdr_out     <= hdr_in;
        descr_state <= data_in[63:64-SW];
      end
    end
  end

  eth_phy_10g_ber_mon #(
    .BER_WINDOW(BER_WINDOW),
    .BER_THRESH(BER_THRESH)
  ) u_ber_mon (
    .clk      (clk),
    .reset    (reset),
    .aligned  (aligned),
    .valid    (valid_in),
    .hdr      (hdr_in),
    .hi_ber   (hi_ber),
    .err_count(err_count)
  );

endmodule

// File: tb/tb_eth_phy_10g_rx_descrambler.sv
// Self-checking bench: bit-serial scrambler/descrambler reference and window-based BER reference.
module tb_eth_phy_10g_rx_descrambler;

  localparam int unsigned WIN = 64;
  localparam int unsigned THR = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        aligned;
  logic        valid_in;
  logic [63:0] data_in;
  logic [1:0]  hdr_in;
  logic [63:0] data_out;
  logic [1:0]  hdr_out;
  logic        valid_out;
  logic        hi_ber;
  logic [5:0]  err_count;

  always #5 clk = ~clk;

  eth_phy_10g_rx_descrambler #(
    .BER_WINDOW(WIN),
    .BER_THRESH(THR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .aligned  (aligned),
    .valid_in (valid_in),
    .data_in  (data_in),
    .hdr_in   (hdr_in),
    .data_out (data_out),
    .hdr_out  (hdr_out),
    .valid_out(valid_out),
    .hi_ber   (hi_ber),
    .err_count(err_count)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  bit tx_hist[$];
  bit rx_hist[$];

  logic [63:0] e_data;
  logic [1:0]  e_hdr;
  logic        e_valid;
  logic        m_hi;
  int          m_err;
  int          m_cnt;
  logic [63:0] orig;
  logic [63:0] last_orig;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] scramble(input logic [63:0] d);
    logic [63:0] r;
    bit b;
    for (int k = 0; k < 64; k++) begin
      b = d[k] ^ tx_hist[tx_hist.size()-39] ^ tx_hist[tx_hist.size()-58];
      r[k] = b;
      tx_hist.push_back(b);
      void'(tx_hist.pop_front());
    end
    return r;
  endfunction

  function automatic logic [63:0] descramble(input logic [63:0] d);
    logic [63:0] r;
    for (int k = 0; k < 64; k++) begin
      r[k] = d[k] ^ rx_hist[rx_hist.size()-39] ^ rx_hist[rx_hist.size()-58];
      rx_hist.push_back(d[k]);
      void'(rx_hist.pop_front());
    end
    return r;
  endfunction

  task automatic model_reset();
    rx_hist.delete();
    repeat (58) rx_hist.push_back(1'b0);
    e_data = '0; e_hdr = '0; e_valid = 1'b0;
    m_hi = 1'b0; m_err = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_data"},  data_out,            e_data);
    chk({ph, "_hdr"},   64'(hdr_out),        64'(e_hdr));
    chk({ph, "_valid"}, 64'(valid_out),      64'(e_valid));
    chk({ph, "_hiber"}, 64'(hi_ber),         64'(m_hi));
    chk({ph, "_err"},   64'(err_count),      64'(m_err));
  endtask

  task automatic step(input string ph, input logic al, input logic v,
                      input logic [63:0] d, input logic [1:0] h);
    aligned = al; valid_in = v; data_in = d; hdr_in = h;
    @(posedge clk);
    e_valid = al & v;
    if (!al) begin
      m_hi = 1'b0; m_err = 0; m_cnt = 0;
    end else if (v) begin
      e_data = descramble(d);
      e_hdr  = h;
      if (h == 2'b00 || h == 2'b11) m_err = (m_err >= 63) ? 63 : m_err + 1;
      if (m_err >= int'(THR)) m_hi = 1'b1;
      if (m_cnt == int'(WIN) - 1) begin
        m_hi  = (m_err >= int'(THR));
        m_err = 0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    #1;
    check_all(ph);
  endtask

  task automatic blk(input string ph, input logic [1:0] h);
    orig = {$urandom, $urandom};
    step(ph, 1'b1, 1'b1, scramble(orig), h);
    chk({ph, "_payload"}, data_out, orig);
    last_orig = orig;
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    logic [63:0] d;
    logic        v;

    repeat (58) tx_hist.push_back(1'b0);
    model_reset();
    last_orig = '0;

    reset = 1'b1; aligned = 1'b0; valid_in = 1'b0; data_in = '0; hdr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Impulse response
    step("imp1", 1'b1, 1'b1, 64'h1, 2'b01);
    chk("imp1_const", data_out, 64'h0400_0080_0000_0001);
    step("imp2", 1'b1, 1'b1, 64'h0, 2'b01);
    chk("imp2_const", data_out, 64'h0);
    chk("imp2_valid", 64'(valid_out), 64'h1);

    // Round trip through the scrambler reference
    for (int i = 0; i < 1000; i++) begin
      orig = {$urandom, $urandom};
      step("rt", 1'b1, 1'b1, scramble(orig), good_hdr());
      if (i >= 2) chk("rt_payload", data_out, orig);
      last_orig = orig;
    end
    chk("rt_hiber_end", 64'(hi_ber), 64'h0);

    // Valid gaps: pattern 1,0,0,1 with garbage on idle cycles
    for (int i = 0; i < 40; i++) begin
      v = (i % 4 == 0) || (i % 4 == 3);
      if (v) begin
        orig = {$urandom, $urandom};
        d = scramble(orig);
        last_orig = orig;
      end else begin
        d = {$urandom, $urandom};
      end
      step("gap", 1'b1, v, d, good_hdr());
      chk("gap_payload", data_out, last_orig);
    end

    // Drop lock for one cycle so the window starts from block 0
    step("sync", 1'b0, 1'b0, 64'h0, 2'b01);

    for (int i = 0; i < 15; i++) blk("thr", 2'b11);
    chk("thr_err15", 64'(err_count), 64'd15);
    chk("thr_hi_lo", 64'(hi_ber), 64'd0);
    blk("thr16", 2'b11);
    chk("thr16_hi", 64'(hi_ber), 64'd1);
    for (int i = 16; i < 64; i++) blk("thr_tail", good_hdr());
    chk("roll1_err", 64'(err_count), 64'd0);
    chk("roll1_hi", 64'(hi_ber), 64'd1);

    for (int i = 0; i < 63; i++) blk("clean", good_hdr());
    chk("clean_hi_held", 64'(hi_ber), 64'd1);
    blk("clean_last", good_hdr());
    chk("clean_hi_drop", 64'(hi_ber), 64'd0);
    chk("clean_err", 64'(err_count), 64'd0);

    for (int i = 0; i < 64; i++) begin
      blk("edge", (i < 15 || i == 63) ? 2'b00 : good_hdr());
      if (i == 62) chk("edge_err15", 64'(err_count), 64'd15);
    end
    chk("edge_hi", 64'(hi_ber), 64'd1);
    chk("edge_err", 64'(err_count), 64'd0);

    // Lock loss while in HI_BER
    step("lock_loss", 1'b0, 1'b1, {$urandom, $urandom}, 2'b01);
    chk("ll_hi", 64'(hi_ber), 64'd0);
    chk("ll_valid", 64'(valid_out), 64'd0);
    chk("ll_hold", data_out, last_orig);

    // Relock, accumulate some errors, then asynchronous reset mid-window
    for (int i = 0; i < 10; i++) blk("pre_rst", (i % 3 == 0) ? 2'b11 : good_hdr());
    #2;
    reset = 1'b1;
    aligned = 1'b0;
    valid_in = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    reset = 1'b0;
    step("post_rst", 1'b0, 1'b0, 64'h0, 2'b01);

    // Transmit scrambler keeps its state; receiver must self-synchronise
    for (int i = 0; i < 6; i++) begin
      orig = {$urandom, $urandom};
      step("relock", 1'b1, 1'b1, scramble(orig), 2'b01);
      if (i >= 1) chk("relock_payload", data_out, orig);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
